// File: rtl/sc_reg_bank.sv
// sc_reg_bank: small register bank with per-register ALU-style operations
// (load, clear, increment, decrement, shifts) and a multi-cycle rotate
// sequenced by a two-state FSM. Two combinational read ports; carry, zero
// and busy flags are registered.
module sc_reg_bank #(
  parameter int RegBANK_DATAWIDTH = 8,
  parameter int RegBANK_DEPTH     = 4,
  parameter int RegBANK_ADDRWIDTH = 2,
  parameter int RegBANK_CNTWIDTH  = 3
) (
  input  logic                         SC_RegBANK_CLOCK_50,
  input  logic                         SC_RegBANK_RESET_InLow,
  input  logic                         SC_RegBANK_load_InLow,
  input  logic [2:0]                   SC_RegBANK_mode_InBUS,
  input  logic [RegBANK_ADDRWIDTH-1:0] SC_RegBANK_wrAddr_InBUS,
  input  logic [RegBANK_DATAWIDTH-1:0] SC_RegBANK_data_InBUS,
  input  logic                         SC_RegBANK_serial_In,
  input  logic [RegBANK_ADDRWIDTH-1:0] SC_RegBANK_rdAddrA_InBUS,
  input  logic [RegBANK_ADDRWIDTH-1:0] SC_RegBANK_rdAddrB_InBUS,
  output logic [RegBANK_DATAWIDTH-1:0] SC_RegBANK_dataA_OutBUS,
  output logic [RegBANK_DATAWIDTH-1:0] SC_RegBANK_dataB_OutBUS,
  output logic                         SC_RegBANK_carry_Out,
  output logic                         SC_RegBANK_zero_Out,
  output logic                         SC_RegBANK_busy_Out
);

  localparam int W  = RegBANK_DATAWIDTH;
  localparam int AW = RegBANK_ADDRWIDTH;
  localparam int CW = RegBANK_CNTWIDTH;
  localparam int D  = RegBANK_DEPTH;

  // One extra bit so DEPTH == 2**AW is representable for the range check.
  localparam logic [AW:0] DEPTH_L = (AW+1)'(D);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_CLEAR = 3'b010;
  localparam logic [2:0] MODE_INC   = 3'b011;
  localparam logic [2:0] MODE_DEC   = 3'b100;
  localparam logic [2:0] MODE_SHL   = 3'b101;
  localparam logic [2:0] MODE_SHR   = 3'b110;
  localparam logic [2:0] MODE_ROT   = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ROTATE = 1'b1
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [W-1:0]   regs_r [D];
  logic [AW-1:0]  rot_addr_r, rot_addr_nxt_s;
  logic [CW-1:0]  rot_cnt_r, rot_cnt_nxt_s;
  logic           carry_r, carry_nxt_s;
  logic           zero_r, zero_nxt_s;

  logic           accept_s;
  logic           upd_s;
  logic           op_carry_s;
  logic [W-1:0]   op_res_s;
  logic           wr_en_s;
  logic [AW-1:0]  wr_idx_s;
  logic [W-1:0]   wr_data_s;
  logic [W-1:0]   cur_s;
  logic [W-1:0]   rot_cur_s;
  logic [W-1:0]   rot_res_s;
  logic [W-1:0]   data_a_s;
  logic [W-1:0]   data_b_s;
  logic [CW-1:0]  rot_n_s;

  // Read muxes: OR of one-hot selected entries, unmatched addresses read 0.
  always_comb begin
    data_a_s  = '0;
    data_b_s  = '0;
    cur_s     = '0;
    rot_cur_s = '0;
    for (int i = 0; i < D; i++) begin
      data_a_s  = data_a_s  | ((SC_RegBANK_rdAddrA_InBUS == AW'(i)) ? regs_r[i] : '0);
      data_b_s  = data_b_s  | ((SC_RegBANK_rdAddrB_InBUS == AW'(i)) ? regs_r[i] : '0);
      cur_s     = cur_s     | ((SC_RegBANK_wrAddr_InBUS  == AW'(i)) ? regs_r[i] : '0);
      rot_cur_s = rot_cur_s | ((rot_addr_r               == AW'(i)) ? regs_r[i] : '0);
    end
  end

  assign SC_RegBANK_dataA_OutBUS = data_a_s;
  assign SC_RegBANK_dataB_OutBUS = data_b_s;
  assign SC_RegBANK_carry_Out    = carry_r;
  assign SC_RegBANK_zero_Out     = zero_r;
  assign SC_RegBANK_busy_Out     = (state_r == ST_ROTATE);

  assign rot_n_s   = SC_RegBANK_data_InBUS[CW-1:0];
  assign rot_res_s = {rot_cur_s[W-2:0], rot_cur_s[W-1]};
  assign accept_s  = (SC_RegBANK_load_InLow == 1'b0) && (state_r == ST_IDLE) &&
                     ({1'b0, SC_RegBANK_wrAddr_InBUS} < DEPTH_L);

  // Single-cycle operation decode: result, carry and whether it commits.
  always_comb begin
    upd_s      = 1'b0;
    op_res_s   = cur_s;
    op_carry_s = 1'b0;
    if (accept_s) begin
      case (SC_RegBANK_mode_InBUS)
        MODE_HOLD: begin
          upd_s = 1'b0;
        end
        MODE_LOAD: begin
          upd_s    = 1'b1;
          op_res_s = SC_RegBANK_data_InBUS;
        end
        MODE_CLEAR: begin
          upd_s    = 1'b1;
          op_res_s = '0;
        end
        MODE_INC: begin
          upd_s      = 1'b1;
          op_res_s   = cur_s + W'(1);
          op_carry_s = &cur_s;
        end
        MODE_DEC: begin
          upd_s      = 1'b1;
          op_res_s   = cur_s - W'(1);
          op_carry_s = (cur_s == '0);
        end
        MODE_SHL: begin
          upd_s      = 1'b1;
          op_res_s   = {cur_s[W-2:0], SC_RegBANK_serial_In};
          op_carry_s = cur_s[W-1];
        end
        MODE_SHR: begin
          upd_s      = 1'b1;
          op_res_s   = {SC_RegBANK_serial_In, cur_s[W-1:1]};
          op_carry_s = cur_s[0];
        end
        MODE_ROT: begin
          // A zero count is a no-change single-cycle op; otherwise the FSM takes over.
          upd_s = (rot_n_s == CW'(0));
        end
        default: begin
          upd_s = 1'b0;
        end
      endcase
    end else begin
      upd_s = 1'b0;
    end
  end

  // FSM next state, bank write port and flag updates.
  always_comb begin
    state_nxt_s    = state_r;
    rot_addr_nxt_s = rot_addr_r;
    rot_cnt_nxt_s  = rot_cnt_r;
    carry_nxt_s    = carry_r;
    zero_nxt_s     = zero_r;
    wr_en_s        = 1'b0;
    wr_idx_s       = SC_RegBANK_wrAddr_InBUS;
    wr_data_s      = op_res_s;
    case (state_r)
      ST_IDLE: begin
        if (upd_s) begin
          wr_en_s     = 1'b1;
          carry_nxt_s = op_carry_s;
          zero_nxt_s  = (op_res_s == '0);
        end else if (accept_s && (SC_RegBANK_mode_InBUS == MODE_ROT)) begin
          state_nxt_s    = ST_ROTATE;
          rot_addr_nxt_s = SC_RegBANK_wrAddr_InBUS;
          rot_cnt_nxt_s  = rot_n_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ROTATE: begin
        wr_en_s       = 1'b1;
        wr_idx_s      = rot_addr_r;
        wr_data_s     = rot_res_s;
        rot_cnt_nxt_s = rot_cnt_r - CW'(1);
        if (rot_cnt_r == CW'(1)) begin
          state_nxt_s = ST_IDLE;
          carry_nxt_s = 1'b0;
          zero_nxt_s  = (rot_res_s == '0);
        end else begin
          state_nxt_s = ST_ROTATE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, bank and flag registers with asynchronous clear.
  always_ff @(posedge SC_RegBANK_CLOCK_50 or negedge SC_RegBANK_RESET_InLow) begin
    if (!SC_RegBANK_RESET_InLow) begin
      state_r    <= ST_IDLE;
      rot_addr_r <= '0;
      rot_cnt_r  <= '0;
      carry_r    <= 1'b0;
      zero_r     <= 1'b0;
      for (int i = 0; i < D; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      state_r    <= state_nxt_s;
      rot_addr_r <= rot_addr_nxt_s;
      rot_cnt_r  <= rot_cnt_nxt_s;
      carry_r    <= carry_nxt_s;
      zero_r     <= zero_nxt_s;
      for (int i = 0; i < D; i++) begin
        if (wr_en_s && (wr_idx_s == AW'(i))) begin
          regs_r[i] <= wr_data_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_reg_bank.sv
// tb_sc_reg_bank: directed + random stimulus against a behavioural model.
// Expected read-port/flag values are queued per cycle by the stimulus and
// popped/compared by an independent monitor on the falling clock edge.
module tb_sc_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld;
  logic [2:0] mode;
  logic [2:0] wa;
  logic [7:0] data;
  logic       ser;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [7:0] da;
  logic [7:0] db;
  logic       carry;
  logic       zero;
  logic       busy;

  always #5 clk = ~clk;

  // Address width 3 with depth 4 leaves addresses 4..7 out of range.
  sc_reg_bank #(
    .RegBANK_DATAWIDTH(8),
    .RegBANK_DEPTH(4),
    .RegBANK_ADDRWIDTH(3),
    .RegBANK_CNTWIDTH(3)
  ) dut (
    .SC_RegBANK_CLOCK_50     (clk),
    .SC_RegBANK_RESET_InLow  (rst_n),
    .SC_RegBANK_load_InLow   (ld),
    .SC_RegBANK_mode_InBUS   (mode),
    .SC_RegBANK_wrAddr_InBUS (wa),
    .SC_RegBANK_data_InBUS   (data),
    .SC_RegBANK_serial_In    (ser),
    .SC_RegBANK_rdAddrA_InBUS(ra),
    .SC_RegBANK_rdAddrB_InBUS(rb),
    .SC_RegBANK_dataA_OutBUS (da),
    .SC_RegBANK_dataB_OutBUS (db),
    .SC_RegBANK_carry_Out    (carry),
    .SC_RegBANK_zero_Out     (zero),
    .SC_RegBANK_busy_Out     (busy)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       z;
    logic       bsy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model state
  logic [7:0] m_reg [4];
  int         m_busy;
  int         m_raddr;
  logic       m_carry;
  logic       m_zero;

  function automatic logic [7:0] m_read(input logic [2:0] a);
    if (a < 3'd4) return m_reg[a[1:0]];
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_busy  = 0;
    m_raddr = 0;
    m_carry = 1'b0;
    m_zero  = 1'b0;
  endtask

  // Effect of one rising edge with the given inputs (reset inactive).
  task automatic model_edge(input logic l, input logic [2:0] md, input logic [2:0] a,
                            input logic [7:0] d, input logic s);
    logic [7:0] old;
    logic [7:0] res;
    logic       c;
    bit         upd;
    if (m_busy > 0) begin
      m_reg[m_raddr] = rotl(m_reg[m_raddr]);
      m_busy--;
      if (m_busy == 0) begin
        m_carry = 1'b0;
        m_zero  = (m_reg[m_raddr] == 8'h00);
      end
    end else if (l == 1'b0 && a < 3'd4) begin
      old = m_reg[a[1:0]];
      res = old;
      c   = 1'b0;
      upd = 1'b1;
      case (md)
        3'd0: upd = 1'b0;
        3'd1: res = d;
        3'd2: res = 8'h00;
        3'd3: begin res = old + 8'd1; c = (old == 8'hFF); end
        3'd4: begin res = old - 8'd1; c = (old == 8'h00); end
        3'd5: begin res = {old[6:0], s}; c = old[7]; end
        3'd6: begin res = {s, old[7:1]}; c = old[0]; end
        default: begin
          if (d[2:0] != 3'd0) begin
            upd     = 1'b0;
            m_busy  = int'(d[2:0]);
            m_raddr = int'(a[1:0]);
          end
        end
      endcase
      if (upd) begin
        m_reg[a[1:0]] = res;
        m_carry       = c;
        m_zero        = (res == 8'h00);
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.a   = m_read(ra);
    e.b   = m_read(rb);
    e.c   = m_carry;
    e.z   = m_zero;
    e.bsy = (m_busy != 0);
    exp_q.push_back(e);
  endtask

  // Called at posedge+1: drive inputs, queue expected view, take one edge.
  task automatic cycle(input logic l, input logic [2:0] md, input logic [2:0] a,
                       input logic [7:0] d, input logic s,
                       input logic [2:0] rda, input logic [2:0] rdb);
    ld = l; mode = md; wa = a; data = d; ser = s; ra = rda; rb = rdb;
    push_exp();
    @(posedge clk);
    #1;
    model_edge(l, md, a, d, s);
  endtask

  task automatic idle(input logic [2:0] rda, input logic [2:0] rdb);
    cycle(1'b1, 3'd0, 3'd0, 8'h00, 1'b0, rda, rdb);
  endtask

  // Reset held low for one cycle, asserted mid-cycle.
  task automatic reset_pulse(input logic [2:0] rda, input logic [2:0] rdb);
    rst_n = 1'b0;
    ld = 1'b1; ra = rda; rb = rdb;
    model_reset();
    push_exp();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("dataA", da, mon_e.a);
      check("dataB", db, mon_e.b);
      check("carry", {7'd0, carry}, {7'd0, mon_e.c});
      check("zero",  {7'd0, zero},  {7'd0, mon_e.z});
      check("busy",  {7'd0, busy},  {7'd0, mon_e.bsy});
    end
  end

  initial begin
    rst_n = 1'b0; ld = 1'b1; mode = 3'd0; wa = 3'd0; data = 8'h00;
    ser = 1'b0; ra = 3'd0; rb = 3'd0;
    model_reset();
    @(posedge clk);
    #1;
    reset_pulse(3'd2, 3'd2);

    // LOAD R2 and read on both ports
    cycle(1'b0, 3'd1, 3'd2, 8'hA5, 1'b0, 3'd2, 3'd2);
    idle(3'd2, 3'd2);
    // INC wrap and DEC wrap on R1
    cycle(1'b0, 3'd1, 3'd1, 8'hFF, 1'b0, 3'd1, 3'd2);
    cycle(1'b0, 3'd3, 3'd1, 8'h00, 1'b0, 3'd1, 3'd1);
    cycle(1'b0, 3'd4, 3'd1, 8'h00, 1'b0, 3'd1, 3'd1);
    idle(3'd1, 3'd1);
    // Shifts on R0
    cycle(1'b0, 3'd1, 3'd0, 8'h81, 1'b0, 3'd0, 3'd0);
    cycle(1'b0, 3'd5, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
    cycle(1'b0, 3'd6, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0);
    idle(3'd0, 3'd0);
    // HOLD leaves flags alone; out-of-range write ignored; out-of-range read 0
    cycle(1'b0, 3'd0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5);
    cycle(1'b0, 3'd1, 3'd5, 8'h77, 1'b0, 3'd5, 3'd0);
    idle(3'd7, 3'd4);
    // ROT N=3 on R3 with an ignored strobe while busy
    cycle(1'b0, 3'd1, 3'd3, 8'h01, 1'b0, 3'd3, 3'd0);
    cycle(1'b0, 3'd7, 3'd3, 8'h03, 1'b0, 3'd3, 3'd0);
    cycle(1'b0, 3'd1, 3'd0, 8'h55, 1'b0, 3'd3, 3'd0);
    idle(3'd3, 3'd0);
    idle(3'd3, 3'd0);
    idle(3'd3, 3'd0);
    // ROT N=5 on R1 aborted by reset
    cycle(1'b0, 3'd1, 3'd1, 8'h0F, 1'b0, 3'd1, 3'd0);
    cycle(1'b0, 3'd7, 3'd1, 8'h05, 1'b0, 3'd1, 3'd0);
    idle(3'd1, 3'd0);
    idle(3'd1, 3'd0);
    reset_pulse(3'd1, 3'd0);
    cycle(1'b0, 3'd1, 3'd0, 8'h3C, 1'b0, 3'd1, 3'd0);
    idle(3'd0, 3'd1);
    // Set carry, then ROT N=0 on zero R2 clears carry and sets zero
    cycle(1'b0, 3'd4, 3'd3, 8'h00, 1'b0, 3'd3, 3'd2);
    cycle(1'b0, 3'd7, 3'd2, 8'h08, 1'b0, 3'd2, 3'd3);
    idle(3'd2, 3'd3);
    // ROT N=7 (longest), then CLEAR
    cycle(1'b0, 3'd7, 3'd3, 8'h07, 1'b0, 3'd3, 3'd0);
    for (int i = 0; i < 7; i++) idle(3'd3, 3'd0);
    cycle(1'b0, 3'd2, 3'd3, 8'h00, 1'b0, 3'd3, 3'd0);
    idle(3'd3, 3'd0);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_pulse(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end else begin
        cycle(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
              3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)));
      end
    end

    idle(3'd0, 3'd1);
    @(negedge clk);
    @(posedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
